// File: rtl/apb_master_driver_pkg.sv
// Shared state encoding, protocol widths and default parameter values for the APB master driver.
package apb_master_driver_pkg;

  localparam int PROT_WIDTH         = 3;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_NO_OF_SLAVES   = 1;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

endpackage

// File: rtl/apb_master_wait_counter.sv
// Counts ACCESS wait states; expired fires on the wait cycle that would reach MAX_CYCLES.
// Single-cycle decision, no backpressure; MAX_CYCLES=0 disables it entirely.
module apb_master_wait_counter #(
  parameter int MAX_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (MAX_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + CW'(1);
        end
      end

      // Abort on the last allowed wait cycle so exactly MAX_CYCLES stalled cycles are seen.
      assign expired = enable && (count == CW'(MAX_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_driver_fsm.sv
// APB initiator: one command -> SETUP/ACCESS on the bus -> one response; 4 cycles minimum per command.
// cmd_ready only in IDLE; response held until rsp_ready; stalled slaves are aborted by the wait counter.
module apb_master_driver_fsm
  import apb_master_driver_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NO_OF_SLAVES   = DEF_NO_OF_SLAVES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int SEL_WIDTH     = $clog2(NO_OF_SLAVES) + 1
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [STRB_WIDTH-1:0]   cmd_strb,
  input  logic [PROT_WIDTH-1:0]   cmd_prot,
  input  logic [SEL_WIDTH-1:0]    cmd_slave_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [NO_OF_SLAVES-1:0] psel,
  output logic                    penable,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [STRB_WIDTH-1:0]   pstrb,
  output logic [PROT_WIDTH-1:0]   pprot,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  apb_state_e              state;
  logic                    wait_expired;
  logic [NO_OF_SLAVES-1:0] sel_onehot;
  logic                    sel_ok;

  assign sel_onehot = NO_OF_SLAVES'(1) << cmd_slave_sel;
  assign sel_ok     = cmd_slave_sel < SEL_WIDTH'(NO_OF_SLAVES);
  assign cmd_ready  = (state == ST_IDLE);

  apb_master_wait_counter #(
    .MAX_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk    (pclk),
    .rst_n  (preset_n),
    .clear  (state != ST_ACCESS),
    .enable (state == ST_ACCESS && !pready),
    .expired(wait_expired)
  );

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state       <= ST_IDLE;
      psel        <= '0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (sel_ok) begin
              // Bus registers double as the latched command for the whole transfer.
              psel   <= sel_onehot;
              paddr  <= cmd_addr;
              pwrite <= cmd_write;
              pwdata <= cmd_write ? cmd_wdata : '0;
              pstrb  <= cmd_write ? cmd_strb : '0;
              pprot  <= cmd_prot;
              state  <= ST_SETUP;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_slverr  <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
              state       <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
            state       <= ST_RESP;
          end else if (wait_expired) begin
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_driver_fsm.sv
// Directed bench: transaction-level timeline model checked every cycle, plus literal per-command expectations.
module tb_apb_master_driver_fsm;

  localparam int NS = 2;
  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic [1:0]  cmd_slave_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [1:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks = 0;
  int errors = 0;
  int cfg_wait = 0;
  bit chk_en = 0;

  apb_master_driver_fsm #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .cmd_slave_sel(cmd_slave_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: raises pready on the access cycle numbered cfg_wait (0-based); negative = never.
  int acc_cnt = 0;
  always @(posedge pclk) begin
    #1;
    if (penable === 1'b1) begin
      pready = (cfg_wait >= 0 && acc_cnt == cfg_wait);
      acc_cnt++;
    end else begin
      pready = 1'b0;
      acc_cnt = 0;
    end
  end

  // Model: each accepted command becomes a timeline (offset t from the accept edge).
  bit          active = 0;
  bit          after_rst = 1;
  int          t, e_acc, e_rstart;
  logic        e_bad, e_to, e_slverr, e_write;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_strb;
  logic [2:0]  e_prot;
  logic [1:0]  e_psel;

  always @(negedge pclk) begin
    if (chk_en) begin
      if (after_rst) begin
        chk("rst_psel", psel, 0);         chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);       chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);       chk("rst_pprot", pprot, 0);
        chk("rst_pwrite", pwrite, 0);     chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_slverr", rsp_slverr, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
      end else if (!active) begin
        chk("idle_psel", psel, 0);
        chk("idle_penable", penable, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
      end else begin
        logic [1:0] x_psel;
        logic       x_pen, x_rv;
        x_psel = (!e_bad && t >= 1 && t <= 1 + e_acc) ? e_psel : 2'b00;
        x_pen  = !e_bad && t >= 2 && t <= 1 + e_acc;
        x_rv   = t >= e_rstart;
        chk("psel", psel, x_psel);
        chk("penable", penable, x_pen);
        chk("rsp_valid", rsp_valid, x_rv);
        chk("busy_cmd_ready", cmd_ready, 0);
        if (x_psel != 0) begin
          chk("paddr", paddr, e_addr);   chk("pwrite", pwrite, e_write);
          chk("pwdata", pwdata, e_wdata); chk("pstrb", pstrb, e_strb);
          chk("pprot", pprot, e_prot);
        end
        if (x_rv) begin
          chk("rsp_rdata", rsp_rdata, e_rdata);
          chk("rsp_slverr", rsp_slverr, e_slverr);
          chk("rsp_timeout", rsp_timeout, e_to);
        end
      end
      // Advance the model across the coming edge.
      if (!preset_n) begin
        active = 0;
      end else if (active) begin
        if (t >= e_rstart && rsp_ready) active = 0;
        else t++;
      end else if (cmd_valid && !after_rst) begin
        bit ok;
        ok       = cfg_wait >= 0 && cfg_wait < TO;
        e_bad    = int'(cmd_slave_sel) >= NS;
        e_acc    = e_bad ? 0 : (ok ? cfg_wait + 1 : TO);
        e_to     = !e_bad && !ok;
        e_slverr = e_bad || e_to || pslverr;
        e_rdata  = (e_bad || e_to || cmd_write || pslverr) ? 32'h0 : prdata;
        e_rstart = e_bad ? 1 : 2 + e_acc;
        e_psel   = 2'(1 << cmd_slave_sel);
        e_addr   = cmd_addr;
        e_write  = cmd_write;
        e_wdata  = cmd_write ? cmd_wdata : 32'h0;
        e_strb   = cmd_write ? cmd_strb : 4'h0;
        e_prot   = cmd_prot;
        active   = 1;
        t        = 1;
      end
      after_rst = !preset_n;
    end
  end

  task automatic run_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input logic [1:0] sel,
                         input int wait_n, input logic [31:0] rd, input logic err, input int hold,
                         output int lat, output int pen, output logic [31:0] rdata,
                         output logic slv, output logic to);
    int n;
    @(posedge pclk); #1;
    cfg_wait = wait_n; prdata = rd; pslverr = err;
    cmd_addr = addr; cmd_write = wr; cmd_wdata = wdata; cmd_strb = strb;
    cmd_prot = prot; cmd_slave_sel = sel; cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    n = 0;
    do begin
      @(negedge pclk); n++;
    end while (!cmd_ready && n < 20);
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    lat = 0; pen = 0;
    do begin
      @(posedge pclk); #1; cmd_valid = 1'b0;
      @(negedge pclk); lat++;
      if (penable) pen++;
    end while (!rsp_valid && lat < 40);
    rdata = rsp_rdata; slv = rsp_slverr; to = rsp_timeout;
    if (!rsp_valid) chk("rsp_wait_timeout", 0, 1);
    if (hold > 0) begin
      repeat (hold) @(posedge pclk);
      #1; rsp_ready = 1'b1;
    end
    @(posedge pclk); #1; rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, pen, n;
    logic [31:0] rdata;
    logic slv, to;
    preset_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_wdata = 0;
    cmd_strb = 0; cmd_prot = 0; cmd_slave_sel = 0; rsp_ready = 0;
    prdata = 0; pslverr = 0; pready = 0;
    repeat (2) @(posedge pclk);
    #1; chk_en = 1;
    @(posedge pclk); #1; preset_n = 1;
    @(negedge pclk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Zero-wait write.
    run_cmd(32'h10, 1, 32'hA5A5_5A5A, 4'hF, 3'd2, 2'd0, 0, 32'h0, 0, 0, lat, pen, rdata, slv, to);
    chk("wr_latency", lat, 3); chk("wr_penable_cycles", pen, 1);
    chk("wr_rdata", rdata, 0); chk("wr_slverr", slv, 0); chk("wr_timeout", to, 0);

    // Read with 3 wait states on slave 1; pready lands on the last allowed cycle.
    run_cmd(32'h20, 0, 32'h1234, 4'hF, 3'd5, 2'd1, 3, 32'hDEAD_BEEF, 0, 0, lat, pen, rdata, slv, to);
    chk("rd_latency", lat, 6); chk("rd_penable_cycles", pen, 4);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF); chk("rd_slverr", slv, 0); chk("rd_timeout", to, 0);

    // Slave never ready -> abort after 4 wait cycles.
    run_cmd(32'h30, 0, 32'h0, 4'h0, 3'd0, 2'd0, -1, 32'h5555_5555, 0, 0, lat, pen, rdata, slv, to);
    chk("to_latency", lat, 6); chk("to_penable_cycles", pen, 4);
    chk("to_rdata", rdata, 0); chk("to_slverr", slv, 1); chk("to_timeout", to, 1);

    // Ready one cycle too late -> still a timeout.
    run_cmd(32'h34, 0, 32'h0, 4'h0, 3'd1, 2'd1, 4, 32'h7777_7777, 0, 0, lat, pen, rdata, slv, to);
    chk("late_penable_cycles", pen, 4); chk("late_timeout", to, 1); chk("late_rdata", rdata, 0);

    // Write with slave error; response back-pressured for 5 cycles.
    run_cmd(32'h40, 1, 32'hCAFE_0001, 4'h3, 3'd7, 2'd0, 1, 32'h0, 1, 5, lat, pen, rdata, slv, to);
    chk("err_latency", lat, 4); chk("err_penable_cycles", pen, 2);
    chk("err_slverr", slv, 1); chk("err_timeout", to, 0); chk("err_rdata", rdata, 0);

    // Out-of-range slave index: no bus activity.
    run_cmd(32'h50, 1, 32'hFFFF_FFFF, 4'hF, 3'd0, 2'd2, 0, 32'h0, 0, 0, lat, pen, rdata, slv, to);
    chk("bad_latency", lat, 1); chk("bad_penable_cycles", pen, 0);
    chk("bad_slverr", slv, 1); chk("bad_timeout", to, 0);

    // Reset during ACCESS.
    @(posedge pclk); #1;
    cfg_wait = -1; cmd_addr = 32'h60; cmd_write = 0; cmd_slave_sel = 0; cmd_valid = 1;
    n = 0;
    do begin @(negedge pclk); n++; end while (!cmd_ready && n < 20);
    @(posedge pclk); #1; cmd_valid = 0;
    n = 0;
    do begin @(negedge pclk); n++; end while (penable !== 1'b1 && n < 20);
    chk("mid_reset_reached_access", penable, 1);
    @(posedge pclk); #1; preset_n = 0;
    @(posedge pclk); #1; preset_n = 1;
    @(negedge pclk);
    chk("mid_reset_psel", psel, 0); chk("mid_reset_penable", penable, 0);
    chk("mid_reset_rsp_valid", rsp_valid, 0); chk("mid_reset_cmd_ready", cmd_ready, 1);

    // Recovery after reset.
    run_cmd(32'h70, 0, 32'h0, 4'h0, 3'd4, 2'd1, 0, 32'h0BAD_F00D, 0, 0, lat, pen, rdata, slv, to);
    chk("rec_latency", lat, 3); chk("rec_rdata", rdata, 32'h0BAD_F00D); chk("rec_slverr", slv, 0);

    repeat (3) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
